dmem_arbiter: RTL

Two-requester arbiter and sequencer for the single-ported synchronous data memory. It sits between the core's load/store port (requester 0) and a secondary master such as a debug/DMA port (requester 1), and drives the memory's read, write, address and write-data inputs. Arbitration is round-robin per accepted access. A lock mechanism lets one requester perform back-to-back accesses (read-modify-write) with a bounded hold time.

---
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter and sequencer for a single-ported
// synchronous data memory.
//
// Requester 0 is the core load/store port and requester 1 is a secondary
// master. Arbitration is round-robin per accepted access. A requester can
// lock the memory for back-to-back accesses, and the lock is released by
// force after LOCK_MAX cycles.
//
// Build option: define DMEM_ARB_FIXED_PRIO_EN to make requester 0 win every
// conflict in the ARB state. When it is undefined (the default), conflicts
// are resolved round-robin.
module dmem_arbiter #(
  parameter int ADDRSIZE = 5,
  parameter int WORDSIZE = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0Valid,
  input  logic                req0Write,
  input  logic                req0Lock,
  input  logic [ADDRSIZE-1:0] req0Addr,
  input  logic [WORDSIZE-1:0] req0WData,
  output logic                req0Ready,
  input  logic                req1Valid,
  input  logic                req1Write,
  input  logic                req1Lock,
  input  logic [ADDRSIZE-1:0] req1Addr,
  input  logic [WORDSIZE-1:0] req1WData,
  output logic                req1Ready,
  output logic                rsp0Valid,
  output logic [WORDSIZE-1:0] rsp0Data,
  output logic                rsp1Valid,
  output logic [WORDSIZE-1:0] rsp1Data,
  output logic                memRead,
  output logic                memWrite,
  output logic [ADDRSIZE-1:0] memAddress,
  output logic [WORDSIZE-1:0] memWriteData,
  input  logic [WORDSIZE-1:0] memReadData
);

  localparam int CNTW = $clog2(LOCK_MAX) + 1;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t            state;
  logic              lastGrant;
  logic [CNTW-1:0]   lockCnt;
  logic              grant0;
  logic              grant1;
  logic              lockDone;

  // A lock has used up its allowed time once the counter reaches LOCK_MAX-1.
  assign lockDone = (lockCnt == CNTW'(LOCK_MAX - 1));

  // Grant selection. A grant always implies valid, so a grant is an acceptance.
  always_comb begin
    // NOTE: both grants get a default before any branch, so no path leaves
    // them unassigned and no latch is inferred.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      case (state)
        ARB: begin
          if (req0Valid && req1Valid) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            grant0 = 1'b1;
`else
            // The requester that did not win last time wins now.
            grant0 = lastGrant;
            grant1 = !lastGrant;
`endif
          end else begin
            grant0 = req0Valid;
            grant1 = req1Valid;
          end
        end
        LOCK0:   grant0 = req0Valid;
        LOCK1:   grant1 = req1Valid;
        default: begin
          grant0 = 1'b0;
          grant1 = 1'b0;
        end
      endcase
    end
  end

  assign req0Ready = grant0;
  assign req1Ready = grant1;

  // Memory command. When nothing is accepted, the address and data follow
  // requester 0 so that they stay deterministic.
  assign memRead      = (grant0 && !req0Write) || (grant1 && !req1Write);
  assign memWrite     = (grant0 && req0Write) || (grant1 && req1Write);
  assign memAddress   = grant1 ? req1Addr : req0Addr;
  assign memWriteData = grant1 ? req1WData : req0WData;

  // Read data comes straight from the memory. The valid flags mark the owner.
  assign rsp0Data = memReadData;
  assign rsp1Data = memReadData;

  // Sequencer state: response flags, round-robin history and lock tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB;
      lastGrant <= 1'b1;
      lockCnt   <= '0;
      rsp0Valid <= 1'b0;
      rsp1Valid <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments, so every
      // register samples the values that held before this edge.
      rsp0Valid <= grant0 && !req0Write;
      rsp1Valid <= grant1 && !req1Write;

      if (grant0) begin
        lastGrant <= 1'b0;
      end else if (grant1) begin
        lastGrant <= 1'b1;
      end

      case (state)
        ARB: begin
          lockCnt <= '0;
          if (grant0 && req0Lock) begin
            state <= LOCK0;
          end else if (grant1 && req1Lock) begin
            state <= LOCK1;
          end
        end
        LOCK0: begin
          // Release takes priority over any lock request made in this cycle.
          if (lockDone || (grant0 && !req0Lock)) begin
            state   <= ARB;
            lockCnt <= '0;
          end else begin
            lockCnt <= lockCnt + CNTW'(1);
          end
        end
        LOCK1: begin
          if (lockDone || (grant1 && !req1Lock)) begin
            state   <= ARB;
            lockCnt <= '0;
          end else begin
            lockCnt <= lockCnt + CNTW'(1);
          end
        end
        default: begin
          state   <= ARB;
          lockCnt <= '0;
        end
      endcase
    end
  end

endmodule
